// File: rtl/debug_pkg.sv
// debug_pkg: shared constants and helpers for the board debug front end.
//   HEX_SEG   - hex digit to active-low segment code (dp off, [7]=dp, [6:0]=g..a)
//   SEG_DASH  - code shown for an out-of-range channel select
//   SEG_BLANK - all segments off (reset value)
//   snap_t    - the word latched for one full display scan
//   clog2     - counter width helper (never returns less than 1)
package debug_pkg;

   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Entry 0 is the rightmost element.
   localparam logic [15:0][7:0] HEX_SEG = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   typedef struct packed {
      logic        valid;   // select was in range when latched
      logic        hb;      // heartbeat value shown on the digit-0 dp
      logic [15:0] data;
   } snap_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw push button, debounces it and flags
// the accepted 0->1 transition.
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   btn_i   - raw asynchronous button, active-high
//   level_o - debounced button level
//   rise_o  - one-cycle strobe, high in the first cycle level_o is 1
module btn_debounce
   import debug_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);

   localparam int            CW      = clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   logic          rise_q, rise_d;

   // Counter only runs while the synchronised input disagrees with the
   // accepted level; any agreement (i.e. a bounce back) restarts it.
   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (sync_q[1] == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         lvl_d = sync_q[1];
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign rise_d = lvl_d & ~lvl_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         cnt_q  <= '0;
         lvl_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
         rise_q <= rise_d;
      end
   end

   assign level_o = lvl_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/debug_display_unit.sv
// debug_display_unit: board debug front end for the single-cycle CPU.
// Turns debounced step-button presses (or a free-running timer) into a
// one-cycle CPU step strobe, and scans one of CHANNELS 16-bit debug words
// onto a 4-digit common-anode 7-segment display.
//   clk         - board clock
//   Reset       - asynchronous active-low reset
//   sel         - channel select
//   chan_data   - channel k at [16k+15:16k]
//   step_button - raw step button, active-high
//   run_mode    - 1 = auto-step every RUN_CYCLES, 0 = manual step
//   step_pulse  - one-cycle CPU advance strobe
//   enable      - digit anodes, active-low
//   dispcode    - segments, active-low, [7]=dp
module debug_display_unit
   import debug_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int SEL_W           = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SCAN_CYCLES     = 100000,
   parameter int RUN_CYCLES      = 50000000
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic [SEL_W-1:0]         sel,
   input  logic [CHANNELS*16-1:0]   chan_data,
   input  logic                     step_button,
   input  logic                     run_mode,
   output logic                     step_pulse,
   output logic [3:0]               enable,
   output logic [7:0]               dispcode
);

   localparam int             SCW      = clog2(SCAN_CYCLES);
   localparam int             RCW      = clog2(RUN_CYCLES);
   localparam logic [SCW-1:0] SCAN_MAX = SCW'(SCAN_CYCLES - 1);
   localparam logic [RCW-1:0] RUN_MAX  = RCW'(RUN_CYCLES - 1);

   logic           btn_level, btn_rise;
   logic [RCW-1:0] run_cnt_q, run_cnt_d;
   logic           step_q, step_d;
   logic           hb_q, hb_d;
   logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]     digit_q, digit_d;
   logic           first_q;
   snap_t          snap_q, snap_d;
   logic [3:0]     enable_q, enable_d;
   logic [7:0]     code_q, code_d;

   logic           run_wrap, scan_wrap, snap_ev;
   logic [15:0]    sel_word;
   logic           sel_valid;
   logic [3:0]     nibble;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk_i  (clk),
      .rst_ni (Reset),
      .btn_i  (step_button),
      .level_o(btn_level),
      .rise_o (btn_rise)
   );

   // Channel mux; an unmatched select leaves sel_valid low.
   always_comb begin
      sel_word  = '0;
      sel_valid = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == SEL_W'(k)) begin
            sel_word  = chan_data[16*k +: 16];
            sel_valid = 1'b1;
         end
      end
   end

   assign run_wrap  = (run_cnt_q == RUN_MAX);
   assign scan_wrap = (scan_cnt_q == SCAN_MAX);
   // first_q catches the very first cycle after reset so digit 0 shows the
   // selected word rather than the cleared reset value.
   assign snap_ev   = first_q | (scan_wrap & (digit_q == 2'd3));

   always_comb begin
      // Run counter is held at 0 in manual mode so entering auto mode
      // always gives a full period before the first pulse.
      run_cnt_d = '0;
      if (run_mode && !run_wrap) run_cnt_d = run_cnt_q + 1'b1;

      // In auto mode the button is ignored; debouncing still tracks it so a
      // held button does not fire when returning to manual mode.
      step_d = run_mode ? run_wrap : (btn_rise & btn_level);
      hb_d   = hb_q ^ step_q;

      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      digit_d    = scan_wrap ? digit_q + 2'd1 : digit_q;

      snap_d = snap_q;
      if (snap_ev) begin
         snap_d.valid = sel_valid;
         snap_d.hb    = hb_q;
         snap_d.data  = sel_word;
      end

      // Outputs are built from next-state digit/word and registered together
      // so anode and segment changes land on the same edge.
      nibble   = snap_d.data[4*digit_d +: 4];
      enable_d = ~(4'b0001 << digit_d);
      if (!snap_d.valid) begin
         code_d = SEG_DASH;
      end else begin
         code_d    = HEX_SEG[nibble];
         code_d[7] = (digit_d == 2'd0) ? ~snap_d.hb : 1'b1;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         run_cnt_q  <= '0;
         step_q     <= 1'b0;
         hb_q       <= 1'b0;
         scan_cnt_q <= '0;
         digit_q    <= '0;
         first_q    <= 1'b1;
         snap_q     <= '0;
         enable_q   <= 4'hF;
         code_q     <= SEG_BLANK;
      end else begin
         run_cnt_q  <= run_cnt_d;
         step_q     <= step_d;
         hb_q       <= hb_d;
         scan_cnt_q <= scan_cnt_d;
         digit_q    <= digit_d;
         first_q    <= 1'b0;
         snap_q     <= snap_d;
         enable_q   <= enable_d;
         code_q     <= code_d;
      end
   end

   assign step_pulse = step_q;
   assign enable     = enable_q;
   assign dispcode   = code_q;

endmodule

// File: tb/tb_debug_display_unit.sv
// Self-checking bench for debug_display_unit with small timing parameters.
module tb_debug_display_unit;

   localparam int CH = 3, SW = 2, DEB = 4, SCAN = 3, RUN = 10;
   // Press driven just after an edge: 2 sync edges, DEB stable edges to
   // accept, 1 edge to register the strobe.
   localparam int BTN_LAT = 2 + DEB + 1;

   logic            clk = 1'b0;
   logic            Reset = 1'b0;
   logic [SW-1:0]   sel = '0;
   logic [CH*16-1:0] chan_data = '0;
   logic            step_button = 1'b0;
   logic            run_mode = 1'b0;
   logic            step_pulse;
   logic [3:0]      enable;
   logic [7:0]      dispcode;

   int          tests = 0;
   int          fails = 0;
   bit          hb_m = 1'b0;       // model heartbeat: parity of pulses since reset
   logic [15:0] words [CH];

   always #5 clk = ~clk;

   debug_display_unit #(
      .CHANNELS(CH), .SEL_W(SW), .DEBOUNCE_CYCLES(DEB),
      .SCAN_CYCLES(SCAN), .RUN_CYCLES(RUN)
   ) dut (
      .clk(clk), .Reset(Reset), .sel(sel), .chan_data(chan_data),
      .step_button(step_button), .run_mode(run_mode),
      .step_pulse(step_pulse), .enable(enable), .dispcode(dispcode)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
         4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
         4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
         4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
      endcase
   endfunction

   function automatic logic [7:0] exp_code(input logic [15:0] w, input bit v,
                                           input int d, input bit hb);
      logic [7:0] s;
      if (!v) return 8'hBF;
      s    = seg7(w[4*d +: 4]);
      s[7] = (d == 0) ? ~hb : 1'b1;
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_words();
      for (int k = 0; k < CH; k++) chan_data[16*k +: 16] = words[k];
   endtask

   // Advance until the frame start (digit 3 -> digit 0) is the current sample.
   task automatic sync_frame(input string tag);
      logic [3:0] prev;
      bit         found;
      prev  = 4'hF;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (prev == 4'b0111 && enable == 4'b1110) found = 1'b1;
         prev = enable;
      end
      check({tag, " frame sync"}, found, 1'b1);
   endtask

   // Frame cycles lo..hi; cycle c drives digit c/SCAN.
   task automatic check_cycles(input string tag, input logic [15:0] w, input bit v,
                               input int lo, input int hi, input bit cur);
      logic [3:0] en_e;
      int         d;
      for (int i = lo; i <= hi; i++) begin
         if (!(cur && i == lo)) step();
         d    = i / SCAN;
         en_e = ~(4'b0001 << d);
         check(tag, {enable, dispcode}, {en_e, exp_code(w, v, d, hb_m)});
      end
   endtask

   // Edges base+1..base+n; pulse expected exactly at p1/p2/p3.
   task automatic watch(input string tag, input int base, input int n,
                        input int p1, input int p2, input int p3);
      for (int k = base + 1; k <= base + n; k++) begin
         step();
         check(tag, step_pulse, (k == p1 || k == p2 || k == p3));
      end
   endtask

   initial begin
      int pa, hold, s;
      for (int k = 0; k < CH; k++) words[k] = 16'h0000;

      // Reset state and first digit after release.
      step();
      step();
      check("rst enable", enable, 4'hF);
      check("rst dispcode", dispcode, 8'hFF);
      check("rst pulse", step_pulse, 1'b0);
      Reset = 1'b1;
      step();
      check("post-rst digit0", {enable, dispcode}, {4'b1110, exp_code(16'h0, 1'b1, 0, 1'b0)});

      // Display frames: fixed 3A7F on channel 1, then random channels/words.
      for (int t = 0; t < 3; t++) begin
         for (int k = 0; k < CH; k++) words[k] = 16'($urandom);
         if (t == 0) begin
            s = 1;
            words[1] = 16'h3A7F;
         end else begin
            s = $urandom_range(0, CH - 1);
         end
         sel = SW'(s);
         apply_words();
         sync_frame("display");
         check_cycles("display", words[s], 1'b1, 0, 4*SCAN - 1, 1'b1);
      end

      // Out-of-range select shows dashes on every digit.
      sel = SW'(3);
      sync_frame("oor");
      check_cycles("oor", 16'h0, 1'b0, 0, 4*SCAN - 1, 1'b1);

      // Select change while digit 2 is driven: frame finishes on the old word.
      words[0] = 16'($urandom);
      words[2] = ~words[0];
      apply_words();
      sel = SW'(0);
      sync_frame("snap");
      check_cycles("snap old", words[0], 1'b1, 0, 2*SCAN, 1'b1);
      sel = SW'(2);
      check_cycles("snap old", words[0], 1'b1, 2*SCAN + 1, 4*SCAN - 1, 1'b0);
      check_cycles("snap new", words[2], 1'b1, 0, 4*SCAN - 1, 1'b0);

      // Bouncing press: 1,0,1 at 2-cycle spacing then held.
      step_button = 1'b1;
      watch("bounce", 0, 2, -1, -1, -1);
      step_button = 1'b0;
      watch("bounce", 0, 2, -1, -1, -1);
      step_button = 1'b1;
      watch("press pulse", 0, 12, BTN_LAT, -1, -1);
      hb_m = ~hb_m;
      step_button = 1'b0;
      watch("release", 0, 12, -1, -1, -1);

      // Heartbeat now 1: digit-0 dp lit.
      sync_frame("hb");
      check_cycles("hb dp", words[2], 1'b1, 0, 4*SCAN - 1, 1'b1);

      // Auto run with a press part way through.
      pa = $urandom_range(2, 15);
      run_mode = 1'b1;
      watch("auto", 0, pa, RUN, 2*RUN, 3*RUN);
      step_button = 1'b1;
      watch("auto", pa, 35 - pa, RUN, 2*RUN, 3*RUN);
      hb_m = ~hb_m; hb_m = ~hb_m; hb_m = ~hb_m;
      run_mode = 1'b0;
      watch("manual held", 0, 12, -1, -1, -1);
      step_button = 1'b0;
      watch("manual release", 0, 12, -1, -1, -1);

      // Random-length press so heartbeat is 1 before the mid-run reset.
      hold = $urandom_range(BTN_LAT + 1, BTN_LAT + 7);
      step_button = 1'b1;
      watch("press2", 0, hold, BTN_LAT, -1, -1);
      hb_m = ~hb_m;
      step_button = 1'b0;
      watch("press2 release", 0, 10, -1, -1, -1);

      // Asynchronous reset mid-scan.
      s = $urandom_range(3, 20);
      for (int i = 0; i < s; i++) step();
      #2;
      Reset = 1'b0;
      #1;
      check("mid rst enable", enable, 4'hF);
      check("mid rst dispcode", dispcode, 8'hFF);
      check("mid rst pulse", step_pulse, 1'b0);
      step();
      check("mid rst held", {enable, dispcode}, {4'hF, 8'hFF});
      Reset = 1'b1;
      hb_m = 1'b0;
      step();
      check("mid rst digit0", {enable, dispcode}, {4'b1110, exp_code(words[2], 1'b1, 0, 1'b0)});
      watch("after rst", 0, 15, -1, -1, -1);
      sync_frame("after rst");
      check_cycles("after rst", words[2], 1'b1, 0, 4*SCAN - 1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
